mantissa_normalizer_iter: RTL and testbench

//  Multi-cycle, parametrised post-add/sub normaliser for the FP adder/subtractor datapath.

---
 rtl/mantissa_normalizer_iter.sv | 171 +++++++++++++++++
 tb/tb_mantissa_normalizer_iter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_normalizer_iter.sv
// Post-add/sub mantissa normaliser for the FP adder datapath; left shifts run iteratively.
// Latency: 1 cycle for add/zero/already-normal, 1 + ceil(min(lz, exp-1)/SHIFT_PER_CYCLE) for sub.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE or HOLD&out_ready.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready             input handshake; in_* sampled only on in_valid&in_ready
//   in_mantissa/in_exponent       raw mantissa (hidden bit at MSB) and aligned biased exponent
//   in_operation/in_cout          0 = add, 1 = subtract; adder carry-out (add only)
//   out_valid/out_ready           output handshake; out_* stable while out_valid&!out_ready
//   out_mantissa/out_exponent     normalised mantissa and biased exponent
//   out_zero/out_overflow/out_underflow   mutually exclusive result flags
module mantissa_normalizer_iter #(
  parameter int MANT_W          = 11,
  parameter int EXP_W           = 5,
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mantissa,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic              in_operation,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mantissa,
  output logic [EXP_W-1:0]  out_exponent,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam int LZW = $clog2(MANT_W + 1);
  // Wide enough to compare leading-zero count, exponent and step size directly.
  localparam int SW  = ((EXP_W > LZW) ? EXP_W : LZW) + 1;

  state_t state;

  // Leading-zero count of the working mantissa.
  function automatic logic [LZW-1:0] count_lz(input logic [MANT_W-1:0] m);
    logic found;
    count_lz = '0;
    found    = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      count_lz = count_lz + LZW'(1);
      end
    end
  endfunction

  logic accept;

  assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  // Result of the accept cycle; acc_shift means the value needs iterative left shifts.
  logic [MANT_W-1:0] acc_mant;
  logic [EXP_W-1:0]  acc_exp;
  logic              acc_zero, acc_ovf, acc_unf, acc_shift;

  always_comb begin
    acc_mant  = in_mantissa;
    acc_exp   = in_exponent;
    acc_zero  = 1'b0;
    acc_ovf   = 1'b0;
    acc_unf   = 1'b0;
    acc_shift = 1'b0;
    if (!in_operation) begin
      if (in_cout) begin
        // exp+1 reaching (or input already at) all-ones saturates to Inf.
        if (in_exponent >= (EXP_MAX - EXP_ONE)) begin
          acc_mant = '0;
          acc_exp  = EXP_MAX;
          acc_ovf  = 1'b1;
        end else begin
          acc_mant = {1'b1, in_mantissa[MANT_W-1:1]};
          acc_exp  = in_exponent + EXP_ONE;
        end
      end
    end else if (in_mantissa == '0) begin
      acc_exp  = '0;
      acc_zero = 1'b1;
    end else if (!in_mantissa[MANT_W-1]) begin
      if (in_exponent <= EXP_ONE) begin
        acc_exp = '0;
        acc_unf = 1'b1;
      end else begin
        acc_shift = 1'b1;
      end
    end
  end

  // One SHIFT iteration: step = min(lz, SHIFT_PER_CYCLE, exp-1), so exp never drops below 1 here.
  logic [SW-1:0]     lz_w, exp_m1_w, spc_w, step_w;
  logic [MANT_W-1:0] sh_mant;
  logic [EXP_W-1:0]  sh_exp;
  logic              sh_done, sh_unf;

  always_comb begin
    lz_w     = SW'(count_lz(out_mantissa));
    exp_m1_w = SW'(out_exponent) - SW'(1);
    spc_w    = SW'(SHIFT_PER_CYCLE);
    step_w   = lz_w;
    if (spc_w < step_w)    step_w = spc_w;
    if (exp_m1_w < step_w) step_w = exp_m1_w;
    sh_mant = out_mantissa << step_w;
    sh_exp  = out_exponent - step_w[EXP_W-1:0];
    sh_done = 1'b0;
    sh_unf  = 1'b0;
    if (sh_mant[MANT_W-1]) begin
      sh_done = 1'b1;
    end else if (sh_exp == EXP_ONE) begin
      // Ran out of exponent before normalising: subnormal encoding uses exp 0.
      sh_exp  = '0;
      sh_done = 1'b1;
      sh_unf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_mantissa  <= '0;
      out_exponent  <= '0;
      out_zero      <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (accept) begin
        out_mantissa  <= acc_mant;
        out_exponent  <= acc_exp;
        out_zero      <= acc_zero;
        out_overflow  <= acc_ovf;
        out_underflow <= acc_unf;
        state         <= acc_shift ? SHIFT : HOLD;
        out_valid     <= !acc_shift;
      end else begin
        case (state)
          SHIFT: begin
            out_mantissa  <= sh_mant;
            out_exponent  <= sh_exp;
            out_underflow <= sh_unf;
            if (sh_done) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mantissa_normalizer_iter.sv
// Scoreboard bench for mantissa_normalizer_iter (SHIFT_PER_CYCLE=1 main instance,
// SHIFT_PER_CYCLE=4 second instance for the multi-bit step case).
// Inputs driven just after posedge; outputs and handshakes sampled on negedge.
module tb_mantissa_normalizer_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_operation, in_cout;
  logic [10:0] in_mantissa;
  logic [4:0]  in_exponent;
  logic        out_valid, out_ready;
  logic [10:0] out_mantissa;
  logic [4:0]  out_exponent;
  logic        out_zero, out_overflow, out_underflow;

  logic        b_in_valid, b_in_ready, b_in_operation, b_in_cout;
  logic [10:0] b_in_mantissa;
  logic [4:0]  b_in_exponent;
  logic        b_out_valid, b_out_ready;
  logic [10:0] b_out_mantissa;
  logic [4:0]  b_out_exponent;
  logic        b_out_zero, b_out_overflow, b_out_underflow;

  logic rdy_rand, rdy_force, rdy_rnd_bit;
  assign out_ready = rdy_rand ? rdy_rnd_bit : rdy_force;

  mantissa_normalizer_iter #(.MANT_W(11), .EXP_W(5), .SHIFT_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mantissa(in_mantissa), .in_exponent(in_exponent),
    .in_operation(in_operation), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exponent(out_exponent),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  mantissa_normalizer_iter #(.MANT_W(11), .EXP_W(5), .SHIFT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mantissa(b_in_mantissa), .in_exponent(b_in_exponent),
    .in_operation(b_in_operation), .in_cout(b_in_cout),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_mantissa(b_out_mantissa), .out_exponent(b_out_exponent),
    .out_zero(b_out_zero), .out_overflow(b_out_overflow), .out_underflow(b_out_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rdy_rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rdy_rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // res = {mantissa, exponent, zero, overflow, underflow}
  typedef struct packed {
    logic [18:0] res;
    int          lat;
    int          acc;
  } sb_t;

  function automatic sb_t model(input logic [10:0] m, input logic [4:0] e,
                                input logic op, input logic c, input int spc);
    sb_t r;
    logic [10:0] rm;
    logic [4:0]  re;
    logic        z, o, u;
    int          lz, ei, sh;
    rm = m; re = e; z = 1'b0; o = 1'b0; u = 1'b0;
    r.lat = 1;
    r.acc = 0;
    ei = int'(e);
    if (!op) begin
      if (c) begin
        if (ei + 1 >= 31) begin rm = '0; re = 5'd31; o = 1'b1; end
        else begin rm = (m >> 1) | 11'h400; re = 5'(ei + 1); end
      end
    end else if (m == '0) begin
      re = '0; z = 1'b1;
    end else begin
      lz = 0;
      while (lz < 11 && !m[10 - lz]) lz++;
      if (lz != 0) begin
        if (ei <= 1) begin
          re = '0; u = 1'b1;
        end else begin
          sh = (lz <= ei - 1) ? lz : ei - 1;
          rm = m << sh;
          if (lz <= ei - 1) re = 5'(ei - lz);
          else begin re = '0; u = 1'b1; end
          r.lat = 1 + (sh + spc - 1) / spc;
        end
      end
    end
    r.res = {rm, re, z, o, u};
    return r;
  endfunction

  sb_t  sb[$];
  sb_t  ent;
  logic seen;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        ent     = model(in_mantissa, in_exponent, in_operation, in_cout, 1);
        ent.acc = cyc;
        sb.push_back(ent);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end
          check("result", 32'({out_mantissa, out_exponent, out_zero, out_overflow, out_underflow}),
                32'(sb[0].res));
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [10:0] m, input logic [4:0] e, input logic op, input logic c);
    int  n;
    logic ok;
    in_valid = 1'b1; in_mantissa = m; in_exponent = e; in_operation = op; in_cout = c;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    check("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mantissa = 11'($urandom);
    in_exponent = 5'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb.size() == 0 && !out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [10:0] m, input logic [4:0] e);
    sb_t w;
    int  n;
    w = model(m, e, 1'b1, 1'b0, 4);
    b_in_valid = 1'b1; b_in_mantissa = m; b_in_exponent = e; b_in_operation = 1'b1; b_in_cout = 1'b0;
    @(negedge clk);
    check("spc4_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    check("spc4_latency", 32'(n), 32'(w.lat));
    check("spc4_result", 32'({b_out_mantissa, b_out_exponent, b_out_zero, b_out_overflow, b_out_underflow}),
          32'(w.res));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] m;
    logic [4:0]  e;
    logic        op, c;

    rst_n = 1'b0;
    in_valid = 1'b0; in_mantissa = '0; in_exponent = '0; in_operation = 1'b0; in_cout = 1'b0;
    b_in_valid = 1'b0; b_in_mantissa = '0; b_in_exponent = '0; b_in_operation = 1'b0; b_in_cout = 1'b0;
    b_out_ready = 1'b1;
    rdy_rand = 1'b0; rdy_force = 1'b1;
    seen = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({out_mantissa, out_exponent, out_zero, out_overflow, out_underflow}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed cases
    send(11'h600, 5'd14, 1'b0, 1'b1);
    send(11'h7FF, 5'd30, 1'b0, 1'b1);
    send(11'h123, 5'd31, 1'b0, 1'b1);
    send(11'h001, 5'd20, 1'b1, 1'b0);
    send(11'h010, 5'd3,  1'b1, 1'b0);
    send(11'h000, 5'd9,  1'b1, 1'b0);
    send(11'h4AB, 5'd7,  1'b1, 1'b0);
    send(11'h200, 5'd2,  1'b1, 1'b0);
    send(11'h0F0, 5'd1,  1'b1, 1'b1);
    send(11'h155, 5'd12, 1'b0, 1'b0);
    drain();

    // Random traffic with random downstream stalls
    rdy_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      op = 1'($urandom_range(0, 1));
      if (!op) begin
        c = 1'($urandom_range(0, 1));
        m = 11'($urandom);
        e = c ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 30));
      end else begin
        c = 1'($urandom_range(0, 1));
        m = 11'($urandom) >> $urandom_range(0, 11);
        e = 5'($urandom_range(0, 31));
      end
      send(m, e, op, c);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    // HOLD stability under 5 stalled cycles, then back-to-back reload
    rdy_rand = 1'b0;
    rdy_force = 1'b0;
    send(11'h600, 5'd14, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    in_valid = 1'b1; in_mantissa = 11'h7FF; in_exponent = 5'd30; in_operation = 1'b0; in_cout = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Reset mid-SHIFT
    rdy_rand = 1'b1;
    send(11'h001, 5'd20, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_outputs", 32'({out_mantissa, out_exponent, out_zero, out_overflow, out_underflow}), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(11'h001, 5'd20, 1'b1, 1'b0);
    drain();

    // SHIFT_PER_CYCLE = 4
    run4(11'h001, 5'd20);
    run4(11'h001, 5'd5);
    run4(11'h030, 5'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
